// File: rtl/sockit_cdc_src_if.sv
// Write-port bundle between the traffic source and the sockit_cdc input side.
// The master drives data and request; the slave answers with grant.
interface sockit_cdc_src_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] bus;
  logic          req;
  logic          grt;

  modport master (output bus, output req, input grt);
  modport slave  (input bus, input req, output grt);
endinterface

// File: rtl/sockit_cdc_src.sv
// Programmable traffic source for the sockit_cdc write port: sends a wrapping
// sequence count, with request insertion throttled by a Galois LFSR.
module sockit_cdc_src #(
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 16,
  parameter logic [31:0] SEED = 32'h00000001
) (
  input  logic                    ffi_clk,
  input  logic                    ffi_rst,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  input  logic [CW-1:0]           cfg_len,
  input  logic [31:0]             cfg_prb,
  sockit_cdc_src_if.master        ffi,
  output logic                    sts_busy,
  output logic                    sts_done,
  output logic [CW-1:0]           sts_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [31:0] TAPS = 32'h80200003;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [DW-1:0] bus_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [31:0]   prb_q, prb_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [31:0]   lfsr_nxt;
  logic          xfer;
  logic          last;

  assign xfer     = req_q & ffi.grt;
  assign last     = (cnt_q + CW'(1)) == len_q;
  assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);

  // State register
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge ffi_clk or posedge ffi_rst) begin
    if (ffi_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every combinational output is defaulted first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (cfg_start) state_d = (cfg_len == '0) ? DONE : RUN;
      RUN: begin
        if (xfer && last)  state_d = DONE;
        else if (cfg_stop) state_d = (!req_q || xfer) ? DONE : DRAIN;
      end
      DRAIN:   if (xfer) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: a pending request is held until granted, and the
  // LFSR advances only on cycles that make a fresh request decision.
  always_comb begin
    req_d  = req_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    prb_d  = prb_q;
    lfsr_d = lfsr_q;
    case (state_q)
      IDLE, DONE: begin
        if (cfg_start) begin
          len_d  = cfg_len;
          prb_d  = cfg_prb;
          cnt_d  = '0;
          lfsr_d = SEED;
        end
      end
      RUN: begin
        if (xfer) cnt_d = cnt_q + CW'(1);
        if (state_d == DONE) begin
          req_d = 1'b0;
        end else if (state_d == RUN && (!req_q || xfer)) begin
          req_d  = (lfsr_q <= prb_q);
          lfsr_d = lfsr_nxt;
        end
      end
      DRAIN: begin
        if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          req_d = 1'b0;
        end
      end
      default: req_d = 1'b0;
    endcase
  end

  always_ff @(posedge ffi_clk or posedge ffi_rst) begin
    if (ffi_rst) begin
      req_q    <= 1'b0;
      bus_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      prb_q    <= '0;
      lfsr_q   <= SEED;
      sts_busy <= 1'b0;
      sts_done <= 1'b0;
    end else begin
      req_q    <= req_d;
      bus_q    <= cnt_d[DW-1:0];
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      prb_q    <= prb_d;
      lfsr_q   <= lfsr_d;
      sts_busy <= (state_d == RUN) || (state_d == DRAIN);
      sts_done <= (state_d == DONE);
    end
  end

  assign ffi.req = req_q;
  assign ffi.bus = bus_q;
  assign sts_cnt = cnt_q;

endmodule

// File: tb/tb_sockit_cdc_src.sv
// Directed bench for sockit_cdc_src: hand-computed sequences plus a small
// cycle model of the request/LFSR behaviour for the throttled runs.
module tb_sockit_cdc_src;
  localparam int          DW   = 8;
  localparam int          CW   = 16;
  localparam logic [31:0] SEED = 32'h00000001;
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [31:0] PMAX = 32'hFFFFFFFF;
  localparam logic [31:0] PHALF = 32'h7FFFFFFF;

  logic          ffi_clk;
  logic          ffi_rst;
  logic          cfg_start;
  logic          cfg_stop;
  logic [CW-1:0] cfg_len;
  logic [31:0]   cfg_prb;
  logic          sts_busy;
  logic          sts_done;
  logic [CW-1:0] sts_cnt;

  int n_vec;
  int n_bad;

  // model state: m_st 0=IDLE 1=RUN 2=DRAIN 3=DONE
  logic [31:0] m_lfsr;
  logic [31:0] m_prb;
  int          m_cnt;
  int          m_len;
  int          m_st;
  bit          m_req;

  sockit_cdc_src_if #(.DW(DW)) ffi_if ();

  sockit_cdc_src #(.DW(DW), .CW(CW), .SEED(SEED)) dut (
    .ffi_clk   (ffi_clk),
    .ffi_rst   (ffi_rst),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_len   (cfg_len),
    .cfg_prb   (cfg_prb),
    .ffi       (ffi_if),
    .sts_busy  (sts_busy),
    .sts_done  (sts_done),
    .sts_cnt   (sts_cnt)
  );

  initial ffi_clk = 1'b0;
  always #5 ffi_clk = ~ffi_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction

  task automatic m_edge(input bit g, input bit stop);
    bit x;
    x = m_req & g;
    if (m_st == 1) begin
      if (x) m_cnt++;
      if (x && m_cnt == m_len) begin
        m_req = 1'b0; m_st = 3;
      end else if (stop) begin
        if (!m_req || x) begin m_req = 1'b0; m_st = 3; end
        else m_st = 2;
      end else if (!m_req || x) begin
        m_req  = (m_lfsr <= m_prb);
        m_lfsr = lfsr_step(m_lfsr);
      end
    end else if (m_st == 2) begin
      if (x) begin m_cnt++; m_req = 1'b0; m_st = 3; end
    end
  endtask

  // one clock cycle: drive at negedge, model follows the rising edge
  task automatic cyc(input bit g, input bit stop);
    ffi_if.grt = g;
    cfg_stop   = stop;
    @(posedge ffi_clk);
    m_edge(g, stop);
    @(negedge ffi_clk);
    cfg_stop = 1'b0;
  endtask

  task automatic do_start(input int len, input logic [31:0] prb);
    cfg_len    = CW'(len);
    cfg_prb    = prb;
    cfg_start  = 1'b1;
    ffi_if.grt = 1'b0;
    @(posedge ffi_clk);
    m_len = len; m_prb = prb; m_cnt = 0; m_lfsr = SEED; m_req = 1'b0;
    m_st  = (len == 0) ? 3 : 1;
    @(negedge ffi_clk);
    cfg_start = 1'b0;
  endtask

  task automatic cmp(input string t);
    check({t, " req"}, 32'(ffi_if.req), 32'(m_req));
    if (m_req) check({t, " bus"}, 32'(ffi_if.bus), 32'(m_cnt & 255));
    check({t, " cnt"}, 32'(sts_cnt), 32'(m_cnt));
  endtask

  initial begin
    logic [39:0] pat_a;
    logic [39:0] pat_b;
    bit          seen_req;
    n_vec = 0; n_bad = 0;
    m_st = 0; m_req = 1'b0; m_cnt = 0; m_len = 0; m_lfsr = SEED; m_prb = '0;
    ffi_rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_len = '0; cfg_prb = '0;
    ffi_if.grt = 1'b0;

    // reset state, before any clock edge
    #3;
    check("rst req",  32'(ffi_if.req), 32'd0);
    check("rst bus",  32'(ffi_if.bus), 32'd0);
    check("rst busy", 32'(sts_busy),   32'd0);
    check("rst done", 32'(sts_done),   32'd0);
    check("rst cnt",  32'(sts_cnt),    32'd0);
    @(negedge ffi_clk);
    ffi_rst = 1'b0;
    cyc(1'b1, 1'b0);
    check("idle req", 32'(ffi_if.req), 32'd0);

    // 1: four back-to-back transfers
    do_start(4, PMAX);
    check("t1 busy", 32'(sts_busy), 32'd1);
    check("t1 req0", 32'(ffi_if.req), 32'd0);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t1 req", 32'(ffi_if.req), 32'd1);
      check("t1 bus", 32'(ffi_if.bus), 32'(i));
      cyc(1'b1, 1'b0);
    end
    check("t1 req end", 32'(ffi_if.req), 32'd0);
    check("t1 done",    32'(sts_done),   32'd1);
    check("t1 cnt",     32'(sts_cnt),    32'd4);
    check("t1 busy end", 32'(sts_busy),  32'd0);

    // 2: backpressure holds request and data
    do_start(3, PMAX);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t2 hold req", 32'(ffi_if.req), 32'd1);
      check("t2 hold bus", 32'(ffi_if.bus), 32'd0);
      cyc(1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0);
    check("t2 req", 32'(ffi_if.req), 32'd1);
    check("t2 bus", 32'(ffi_if.bus), 32'd1);
    check("t2 cnt", 32'(sts_cnt),    32'd1);
    for (int i = 0; i < 10 && !sts_done; i++) cyc(1'b1, 1'b0);
    check("t2 done", 32'(sts_done), 32'd1);
    check("t2 cnt end", 32'(sts_cnt), 32'd3);

    // 3: zero-length run
    do_start(0, PMAX);
    check("t3 done", 32'(sts_done), 32'd1);
    check("t3 busy", 32'(sts_busy), 32'd0);
    check("t3 cnt",  32'(sts_cnt),  32'd0);
    seen_req = ffi_if.req;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      seen_req |= ffi_if.req;
    end
    check("t3 no req", 32'(seen_req), 32'd0);

    // 4: 300 transfers, data wraps 255 -> 0 with no gaps
    do_start(300, PMAX);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      check("t4 req/bus", {23'd0, ffi_if.req, ffi_if.bus}, 32'h100 | 32'(i & 255));
      cyc(1'b1, 1'b0);
    end
    check("t4 done", 32'(sts_done), 32'd1);
    check("t4 cnt",  32'(sts_cnt),  32'd300);
    check("t4 req",  32'(ffi_if.req), 32'd0);

    // 5: throttled run, random grant, stop while a request is stalled
    do_start(256, PHALF);
    for (int i = 0; i < 40; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'b0);
      cmp("t5 run");
    end
    for (int i = 0; i < 50 && !m_req; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'b0);
      cmp("t5 seek");
    end
    check("t5 pend", 32'(ffi_if.req), 32'd1);
    cyc(1'b0, 1'b1);
    check("t5 drain busy", 32'(sts_busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cmp("t5 drain");
      cyc(1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0);
    cmp("t5 end");
    check("t5 done", 32'(sts_done), 32'd1);

    // 6: async reset mid-run, restart reproduces the request pattern
    do_start(100, PHALF);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0);
      pat_a[i] = ffi_if.req;
      cmp("t6 a");
    end
    for (int i = 0; i < 50 && !ffi_if.req; i++) cyc(1'b0, 1'b0);
    check("t6 pend", 32'(ffi_if.req), 32'd1);
    #2 ffi_rst = 1'b1;
    #1;
    check("t6 rst req",  32'(ffi_if.req), 32'd0);
    check("t6 rst bus",  32'(ffi_if.bus), 32'd0);
    check("t6 rst busy", 32'(sts_busy),   32'd0);
    check("t6 rst cnt",  32'(sts_cnt),    32'd0);
    @(negedge ffi_clk);
    ffi_rst = 1'b0;
    do_start(100, PHALF);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0);
      pat_b[i] = ffi_if.req;
    end
    check("t6 pat lo", 32'(pat_b[31:0]), 32'(pat_a[31:0]));
    check("t6 pat hi", 32'(pat_b[39:32]), 32'(pat_a[39:32]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
